// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Brief    : Loads a checksummed big-endian byte stream into instruction
//            memory and keeps the CPU held until the image checks good.
// Revision : 1.0
// ============================================================================
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] loaded_words
);

    localparam logic [16:0] c_maxWords = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNTHI = 3'd1,
        S_COUNTLO = 3'd2,
        S_DATA    = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_count;
    logic [23:0] r_shift;
    logic [1:0]  r_byteIdx;
    logic [7:0]  r_checksum;
    logic [31:0] r_addr;

    logic        w_accept;
    logic        w_startOk;
    logic        w_wordDone;
    logic        w_lastWord;
    logic [15:0] w_countNew;

    assign w_accept   = byte_valid && byte_ready;
    assign w_startOk  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_wordDone = w_accept && (r_state == S_DATA) && (r_byteIdx == 2'd3);
    assign w_lastWord = (loaded_words + 16'd1) == r_count;
    assign w_countNew = {r_count[15:8], byte_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        byte_ready  = 1'b0;
        cpu_hold    = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (w_startOk) w_nextState = S_COUNTHI;
            end
            S_COUNTHI: begin
                byte_ready = 1'b1;
                if (w_accept) w_nextState = S_COUNTLO;
            end
            S_COUNTLO: begin
                byte_ready = 1'b1;
                if (w_accept) begin
                    if (w_countNew == 16'd0)                   w_nextState = S_CHECK;
                    else if ({1'b0, w_countNew} > c_maxWords)  w_nextState = S_ERROR;
                    else                                       w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (w_wordDone && w_lastWord) w_nextState = S_CHECK;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                if (w_accept) w_nextState = (byte_data == r_checksum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (w_startOk) w_nextState = S_COUNTHI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (w_startOk) w_nextState = S_COUNTHI;
            end
            default: begin
                cpu_hold    = 1'b0;
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Start and byte acceptance are mutually exclusive by state, so their updates never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            im_we        <= 1'b0;
            im_addr      <= 32'd0;
            im_wdata     <= 32'd0;
            loaded_words <= 16'd0;
            r_count      <= 16'd0;
            r_shift      <= 24'd0;
            r_byteIdx    <= 2'd0;
            r_checksum   <= 8'd0;
            r_addr       <= 32'd0;
        end else begin
            im_we <= 1'b0;
            if (w_startOk) begin
                loaded_words <= 16'd0;
                r_checksum   <= 8'd0;
                r_byteIdx    <= 2'd0;
                r_addr       <= BASE_ADDR;
            end
            if (w_accept) begin
                case (r_state)
                    S_COUNTHI: r_count[15:8] <= byte_data;
                    S_COUNTLO: r_count[7:0]  <= byte_data;
                    S_DATA: begin
                        r_shift    <= {r_shift[15:0], byte_data};
                        r_checksum <= r_checksum ^ byte_data;
                        r_byteIdx  <= r_byteIdx + 2'd1;
                        if (r_byteIdx == 2'd3) begin
                            im_we        <= 1'b1;
                            im_addr      <= r_addr;
                            im_wdata     <= {r_shift, byte_data};
                            r_addr       <= r_addr + 32'd4;
                            loaded_words <= loaded_words + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
